// File: rtl/comm_msg_tx.sv
// Transmit-side framer for the host UART link: builds PONG/INFO/INVALID/ACK/NONCE
// frames (length, reserved, type, payload, CRC-32) and streams them over valid/ready.
module comm_msg_tx #(
  parameter logic [31:0] INFO_WORD0 = 32'hDEADBEEF,
  parameter logic [31:0] INFO_WORD1 = 32'h13370D13,
  parameter bit          CRC_EN     = 1'b1
) (
  input  logic        comm_clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_kind,
  output logic        req_ready,
  input  logic        nonce_valid,
  input  logic [31:0] nonce_in,
  output logic        nonce_overflow,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_CRC, S_PONG} state_t;
  typedef enum logic [1:0] {F_INFO, F_INVALID, F_ACK, F_NONCE} frame_t;

  state_t      state, state_nx;
  frame_t      kind, kind_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [31:0] crc, crc_nx, crc_cur;
  logic [7:0]  data_nx;
  logic        vld_nx;
  logic        pend, start_nonce, xfer;
  logic [31:0] pend_nonce, frame_nonce;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic frame_t to_frame(input logic [1:0] k);
    case (k)
      2'd1:    return F_INFO;
      2'd2:    return F_INVALID;
      default: return F_ACK;
    endcase
  endfunction

  function automatic logic [7:0] hdr_byte(input frame_t k, input logic [1:0] i);
    logic [7:0] b;
    b = 8'h00;
    if (i == 2'd0) begin
      case (k)
        F_INFO:  b = 8'd16;
        F_NONCE: b = 8'd12;
        default: b = 8'd8;
      endcase
    end else if (i == 2'd3) begin
      case (k)
        F_INFO:    b = 8'h00;
        F_INVALID: b = 8'h01;
        F_ACK:     b = 8'h04;
        default:   b = 8'h03;
      endcase
    end
    return b;
  endfunction

  // Payload bytes go out MSB first; a nonce occupies the upper half of the word.
  function automatic logic [7:0] pay_byte(input frame_t k, input logic [2:0] i, input logic [31:0] n);
    logic [63:0] w;
    logic [7:0]  b;
    w = (k == F_INFO) ? {INFO_WORD0, INFO_WORD1} : {n, 32'h0};
    case (i)
      3'd0:    b = w[63:56];
      3'd1:    b = w[55:48];
      3'd2:    b = w[47:40];
      3'd3:    b = w[39:32];
      3'd4:    b = w[31:24];
      3'd5:    b = w[23:16];
      3'd6:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [7:0] crc_byte(input logic [31:0] c, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = c[7:0];
      2'd1:    b = c[15:8];
      2'd2:    b = c[23:16];
      default: b = c[31:24];
    endcase
    return CRC_EN ? ~b : 8'h00;
  endfunction

  assign xfer      = tx_valid && tx_ready;
  assign busy      = (state != S_IDLE);
  assign req_ready = (state == S_IDLE) && !pend && !reset;
  // The byte currently on tx_data is folded in here so the first CRC byte sees it.
  assign crc_cur   = (state == S_HDR || state == S_PAYLOAD) ? crc_upd(crc, tx_data) : crc;

  always_comb begin
    state_nx    = state;
    kind_nx     = kind;
    cnt_nx      = cnt;
    crc_nx      = crc;
    data_nx     = tx_data;
    vld_nx      = tx_valid;
    start_nonce = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend) begin
          start_nonce = 1'b1;
          state_nx    = S_HDR;
          kind_nx     = F_NONCE;
          cnt_nx      = 3'd0;
          crc_nx      = 32'hFFFFFFFF;
          data_nx     = hdr_byte(F_NONCE, 2'd0);
          vld_nx      = 1'b1;
        end else if (req_valid) begin
          kind_nx  = to_frame(req_kind);
          cnt_nx   = 3'd0;
          crc_nx   = 32'hFFFFFFFF;
          vld_nx   = 1'b1;
          state_nx = (req_kind == 2'd0) ? S_PONG : S_HDR;
          data_nx  = (req_kind == 2'd0) ? 8'h01 : hdr_byte(to_frame(req_kind), 2'd0);
        end
      end
      S_HDR: begin
        if (xfer) begin
          crc_nx = crc_cur;
          if (cnt[1:0] != 2'd3) begin
            cnt_nx  = cnt + 3'd1;
            data_nx = hdr_byte(kind, cnt[1:0] + 2'd1);
          end else if (kind == F_INFO || kind == F_NONCE) begin
            state_nx = S_PAYLOAD;
            cnt_nx   = 3'd0;
            data_nx  = pay_byte(kind, 3'd0, frame_nonce);
          end else begin
            state_nx = S_CRC;
            cnt_nx   = 3'd0;
            data_nx  = crc_byte(crc_cur, 2'd0);
          end
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          crc_nx = crc_cur;
          if (cnt != ((kind == F_INFO) ? 3'd7 : 3'd3)) begin
            cnt_nx  = cnt + 3'd1;
            data_nx = pay_byte(kind, cnt + 3'd1, frame_nonce);
          end else begin
            state_nx = S_CRC;
            cnt_nx   = 3'd0;
            data_nx  = crc_byte(crc_cur, 2'd0);
          end
        end
      end
      S_CRC: begin
        if (xfer) begin
          if (cnt[1:0] != 2'd3) begin
            cnt_nx  = cnt + 3'd1;
            data_nx = crc_byte(crc, cnt[1:0] + 2'd1);
          end else begin
            state_nx = S_IDLE;
            cnt_nx   = 3'd0;
            vld_nx   = 1'b0;
          end
        end
      end
      S_PONG: begin
        if (xfer) begin
          state_nx = S_IDLE;
          vld_nx   = 1'b0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        vld_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge comm_clk) begin
    if (reset) begin
      state          <= S_IDLE;
      kind           <= F_ACK;
      cnt            <= 3'd0;
      crc            <= 32'hFFFFFFFF;
      tx_data        <= 8'h00;
      tx_valid       <= 1'b0;
      pend           <= 1'b0;
      nonce_overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      kind     <= kind_nx;
      cnt      <= cnt_nx;
      crc      <= crc_nx;
      tx_data  <= data_nx;
      tx_valid <= vld_nx;
      // A nonce landing in the same cycle its predecessor's frame starts is not an overflow.
      if (nonce_valid) begin
        pend <= 1'b1;
        if (pend && !start_nonce) nonce_overflow <= 1'b1;
      end else if (start_nonce) begin
        pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge comm_clk) begin
    if (nonce_valid) pend_nonce <= nonce_in;
    if (start_nonce) frame_nonce <= pend_nonce;
  end

endmodule

// File: tb/tb_comm_msg_tx.sv
// Bench for comm_msg_tx: frame-level reference model (byte lists + bit-serial CRC),
// table-driven frames, hand-written stall/priority/reset sequences and random traffic.
module tb_comm_msg_tx;
  localparam logic [31:0] W0 = 32'hDEADBEEF;
  localparam logic [31:0] W1 = 32'h13370D13;

  logic        comm_clk = 1'b0;
  logic        reset, req_valid, nonce_valid, tx_ready;
  logic [1:0]  req_kind;
  logic [31:0] nonce_in;
  logic        req_ready, nonce_overflow, tx_valid, busy;
  logic [7:0]  tx_data;
  logic        req_ready0, nonce_overflow0, tx_valid0, busy0;
  logic [7:0]  tx_data0;

  always #5 comm_clk = ~comm_clk;

  comm_msg_tx #(.CRC_EN(1'b1)) dut (
    .comm_clk(comm_clk), .reset(reset), .req_valid(req_valid), .req_kind(req_kind),
    .req_ready(req_ready), .nonce_valid(nonce_valid), .nonce_in(nonce_in),
    .nonce_overflow(nonce_overflow), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy));

  comm_msg_tx #(.CRC_EN(1'b0)) dut0 (
    .comm_clk(comm_clk), .reset(reset), .req_valid(req_valid), .req_kind(req_kind),
    .req_ready(req_ready0), .nonce_valid(nonce_valid), .nonce_in(nonce_in),
    .nonce_overflow(nonce_overflow0), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready), .busy(busy0));

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;
  bit rand_ready = 1'b0;
  logic [7:0] cap[$], cap0[$], exp_q[$], exp0_q[$];
  logic       stall_p = 1'b0, stall0_p = 1'b0;
  logic [7:0] data_p = 8'h00, data0_p = 8'h00;

  typedef struct {
    int         kind;    // 0 PONG, 1 INFO, 2 INVALID, 3 ACK, 4 NONCE
    logic [31:0] nonce;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b3;
  } vec_t;

  // Inputs change #1 after posedge, so negedge sees exactly what the next edge will use.
  always @(negedge comm_clk) begin
    if (stall_p) begin
      checks++;
      if (!tx_valid || tx_data !== data_p) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, data_p);
      end
    end
    if (stall0_p) begin
      checks++;
      if (!tx_valid0 || tx_data0 !== data0_p) begin
        errors++;
        $display("FAIL stall_hold_nocrc: got valid=%b data=%h expected valid=1 data=%h", tx_valid0, tx_data0, data0_p);
      end
    end
    stall_p  = tx_valid && !tx_ready && !reset;
    data_p   = tx_data;
    stall0_p = tx_valid0 && !tx_ready && !reset;
    data0_p  = tx_data0;
    if (tx_valid && tx_ready && !reset) cap.push_back(tx_data);
    if (tx_valid0 && tx_ready && !reset) cap0.push_back(tx_data0);
    if (busy) busy_cycles++;
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge comm_clk);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[j]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[j][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic model_frame(input int k, input logic [31:0] nv);
    logic [7:0]  f[$];
    logic [31:0] c, w;
    if (k == 0) begin
      exp_q.push_back(8'h01);
      exp0_q.push_back(8'h01);
      return;
    end
    f.push_back(k == 1 ? 8'd16 : (k == 4 ? 8'd12 : 8'd8));
    f.push_back(8'h00);
    f.push_back(8'h00);
    f.push_back(k == 1 ? 8'h00 : (k == 2 ? 8'h01 : (k == 3 ? 8'h04 : 8'h03)));
    if (k == 1)
      for (int i = 0; i < 8; i++) begin
        w = (i < 4) ? W0 : W1;
        f.push_back(8'(w >> (24 - 8 * (i % 4))));
      end
    if (k == 4)
      for (int i = 0; i < 4; i++) f.push_back(8'(nv >> (24 - 8 * i)));
    c = crc32(f);
    foreach (f[j]) begin
      exp_q.push_back(f[j]);
      exp0_q.push_back(f[j]);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(c >> (8 * i)));
      exp0_q.push_back(8'h00);
    end
  endtask

  task automatic check_streams(input string name);
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_len: got %0d bytes expected %0d", name, cap.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte%0d: got %h expected %h", name, i, cap[i], exp_q[i]);
      end
    end
    checks++;
    if (cap0.size() != exp0_q.size()) begin
      errors++;
      $display("FAIL %s_nocrc_len: got %0d bytes expected %0d", name, cap0.size(), exp0_q.size());
    end
    for (int i = 0; i < exp0_q.size() && i < cap0.size(); i++) begin
      checks++;
      if (cap0[i] !== exp0_q[i]) begin
        errors++;
        $display("FAIL %s_nocrc_byte%0d: got %h expected %h", name, i, cap0[i], exp0_q[i]);
      end
    end
    cap.delete(); cap0.delete(); exp_q.delete(); exp0_q.delete();
  endtask

  task automatic send_req(input logic [1:0] k);
    int n;
    n = 0;
    @(posedge comm_clk);
    #1;
    req_valid = 1'b1;
    req_kind  = k;
    forever begin
      @(negedge comm_clk);
      if (req_ready) break;
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL req_accept_timeout: got no req_ready expected acceptance");
        break;
      end
    end
    @(posedge comm_clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic pulse_nonce(input logic [31:0] v);
    @(posedge comm_clk);
    #1;
    nonce_valid = 1'b1;
    nonce_in    = v;
    @(posedge comm_clk);
    #1;
    nonce_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int idle, n;
    idle = 0;
    n = 0;
    while (idle < 4) begin
      @(negedge comm_clk);
      idle = busy ? 0 : idle + 1;
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL %s_idle_timeout: got busy expected idle", name);
        break;
      end
    end
  endtask

  initial begin
    vec_t tbl[5];
    logic [7:0] sanity[$];
    logic [7:0] info_lit[16];
    logic [31:0] v;
    int op, n;

    reset = 1'b1; req_valid = 1'b0; req_kind = 2'd0; nonce_valid = 1'b0; nonce_in = 32'h0;

    tbl[0] = '{kind: 0, nonce: 32'h0,        nbytes: 1,  b0: 8'h01, b3: 8'h00};
    tbl[1] = '{kind: 2, nonce: 32'h0,        nbytes: 8,  b0: 8'h08, b3: 8'h01};
    tbl[2] = '{kind: 3, nonce: 32'h0,        nbytes: 8,  b0: 8'h08, b3: 8'h04};
    tbl[3] = '{kind: 1, nonce: 32'h0,        nbytes: 16, b0: 8'h10, b3: 8'h00};
    tbl[4] = '{kind: 4, nonce: 32'h38b9b05a, nbytes: 12, b0: 8'h0c, b3: 8'h03};
    info_lit = '{8'h10, 8'h00, 8'h00, 8'h00, 8'hde, 8'had, 8'hbe, 8'hef,
                 8'h13, 8'h37, 8'h0d, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};

    for (int i = 0; i < 9; i++) sanity.push_back(8'h31 + 8'(i));
    if (crc32(sanity) !== 32'hCBF43926) begin
      $display("FAIL crc_model: got %h expected cbf43926", crc32(sanity));
      $fatal(1, "reference CRC model broken");
    end

    // Reset state
    repeat (3) @(posedge comm_clk);
    @(negedge comm_clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", nonce_overflow, 0);
    @(posedge comm_clk);
    #1;
    reset = 1'b0;
    @(negedge comm_clk);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_tx_valid", tx_valid, 0);
    cap.delete(); cap0.delete();

    // Table-driven frames with tx_ready held high
    for (int t = 0; t < 5; t++) begin
      busy_cycles = 0;
      model_frame(tbl[t].kind, tbl[t].nonce);
      if (tbl[t].kind == 4) pulse_nonce(tbl[t].nonce);
      else send_req(2'(tbl[t].kind));
      wait_idle("tbl");
      chk($sformatf("tbl%0d_nbytes", t), cap.size(), tbl[t].nbytes);
      chk($sformatf("tbl%0d_first", t), cap.size() > 0 ? cap[0] : 8'hxx, tbl[t].b0);
      if (tbl[t].nbytes > 3)
        chk($sformatf("tbl%0d_type", t), cap.size() > 3 ? cap[3] : 8'hxx, tbl[t].b3);
      chk($sformatf("tbl%0d_busy", t), busy_cycles, tbl[t].nbytes);
      check_streams($sformatf("tbl%0d", t));
    end
    chk("no_overflow_yet", nonce_overflow, 0);

    // INFO under random backpressure; the CRC-less instance must match the literal frame
    rand_ready = 1'b1;
    model_frame(1, 32'h0);
    send_req(2'd1);
    wait_idle("info_stall");
    rand_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      chk($sformatf("info_lit%0d", i), cap0.size() > i ? cap0[i] : 8'hxx, info_lit[i]);
    check_streams("info_stall");

    // Nonce priority and overflow while an ACK is in flight
    model_frame(3, 32'h0);
    model_frame(4, 32'h0badf00d);
    model_frame(2, 32'h0);
    send_req(2'd3);
    @(posedge comm_clk);
    #1;
    nonce_valid = 1'b1; nonce_in = 32'h11223344; req_valid = 1'b1; req_kind = 2'd2;
    @(posedge comm_clk);
    #1;
    nonce_valid = 1'b0;
    @(posedge comm_clk);
    #1;
    nonce_valid = 1'b1; nonce_in = 32'h0badf00d;
    @(posedge comm_clk);
    #1;
    nonce_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge comm_clk);
      if (req_ready) break;
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL prio_accept_timeout: got no req_ready expected acceptance");
        break;
      end
    end
    @(posedge comm_clk);
    #1;
    req_valid = 1'b0;
    wait_idle("prio");
    chk("prio_overflow", nonce_overflow, 1);
    chk("prio_overflow_nocrc", nonce_overflow0, 1);
    check_streams("prio");

    // Reset mid-INFO with a nonce pending: frame and nonce are both dropped
    send_req(2'd1);
    pulse_nonce(32'hcafef00d);
    n = 0;
    while (cap.size() < 6 && n < 100) begin
      @(negedge comm_clk);
      n++;
    end
    chk("midrst_reached_byte6", cap.size() >= 6, 1);
    @(posedge comm_clk);
    #1;
    reset = 1'b1;
    @(posedge comm_clk);
    #1;
    reset = 1'b0;
    @(negedge comm_clk);
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overflow", nonce_overflow, 0);
    repeat (3) @(negedge comm_clk);
    chk("midrst_nonce_lost", busy, 0);
    cap.delete(); cap0.delete(); exp_q.delete(); exp0_q.delete();
    model_frame(2, 32'h0);
    send_req(2'd2);
    wait_idle("midrst");
    check_streams("midrst_recover");

    // Random traffic against the frame model
    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 4);
      rand_ready = 1'($urandom_range(0, 1));
      v = $urandom;
      model_frame(op, v);
      if (op == 4) pulse_nonce(v);
      else send_req(2'(op));
      wait_idle("rand");
      check_streams($sformatf("rand%0d", it));
    end
    rand_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
